// File: rtl/mem_arbiter.sv
// Shares the main-memory line port between icache fills and dcache fills/write-backs.
// Round-robin grant, one transaction in flight, fixed per-type latency counted down from the grant.
module mem_arbiter #(
    parameter int ADDR_W     = 26,
    parameter int LINE_W     = 128,
    parameter int RD_LATENCY = 10,
    parameter int WR_LATENCY = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ireq,
    input  logic [ADDR_W-1:0] iaddr,
    output logic [LINE_W-1:0] idata,
    output logic              iready,
    input  logic              dreq,
    input  logic              dwe,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [LINE_W-1:0] dwdata,
    output logic [LINE_W-1:0] ddata,
    output logic              dready,
    output logic              dwack,
    output logic              busy,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [LINE_W-1:0] ram_wdata,
    input  logic [LINE_W-1:0] ram_rdata
);

    localparam int MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [CNT_W-1:0] RD_START = CNT_W'(RD_LATENCY - 1);
    localparam logic [CNT_W-1:0] WR_START = CNT_W'(WR_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               owner_q, owner_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [LINE_W-1:0]  wdata_q, wdata_d;
    logic               last_grant_q, last_grant_d;
    logic               cool_i_q, cool_i_d;
    logic               cool_d_q, cool_d_d;
    logic [LINE_W-1:0]  idata_q, idata_d;
    logic [LINE_W-1:0]  ddata_q, ddata_d;

    logic               elig_i;
    logic               elig_d;
    logic               pick_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            owner_q      <= OWN_I;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            last_grant_q <= OWN_I;
            cool_i_q     <= 1'b0;
            cool_d_q     <= 1'b0;
            idata_q      <= '0;
            ddata_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            last_grant_q <= last_grant_d;
            cool_i_q     <= cool_i_d;
            cool_d_q     <= cool_d_d;
            idata_q      <= idata_d;
            ddata_q      <= ddata_d;
        end
    end

    // A requester served in the previous cycle sits out one cycle so the other side gets a turn.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        last_grant_d = last_grant_q;
        cool_i_d     = 1'b0;
        cool_d_d     = 1'b0;
        idata_d      = idata_q;
        ddata_d      = ddata_q;
        elig_i       = ireq && !cool_i_q;
        elig_d       = dreq && !cool_d_q;
        pick_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (elig_i || elig_d) begin
                    pick_d       = (elig_i && elig_d) ? (last_grant_q == OWN_I) : elig_d;
                    owner_d      = pick_d;
                    we_d         = pick_d && dwe;
                    addr_d       = pick_d ? daddr : iaddr;
                    wdata_d      = pick_d ? dwdata : '0;
                    cnt_d        = (pick_d && dwe) ? WR_START : RD_START;
                    last_grant_d = pick_d;
                    state_d      = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = RESP;
                    if (!we_q) begin
                        if (owner_q == OWN_D) begin
                            ddata_d = ram_rdata;
                        end else begin
                            idata_d = ram_rdata;
                        end
                    end
                end
            end
            RESP: begin
                state_d  = IDLE;
                cool_i_d = (owner_q == OWN_I);
                cool_d_d = (owner_q == OWN_D);
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reads strobe one cycle earlier than writes so the returned line lands before the response.
    always_comb begin
        busy      = (state_q != IDLE);
        ram_en    = (state_q == WAIT) && (cnt_q == (we_q ? CNT_ONE : CNT_TWO));
        ram_we    = ram_en && we_q;
        ram_addr  = addr_q;
        ram_wdata = wdata_q;
        iready    = (state_q == RESP) && (owner_q == OWN_I);
        dready    = (state_q == RESP) && (owner_q == OWN_D) && !we_q;
        dwack     = (state_q == RESP) && (owner_q == OWN_D) && we_q;
        idata     = idata_q;
        ddata     = ddata_q;
    end

endmodule
